combo_prog: RTL and testbench

- Programming stage directly upstream of the lock FSM; owns and drives its 32-bit combination `seq` (8 hex digits, MSD in [31:28]).
- Consumes the keypad encoder's strobe level and 5-bit key code. Synchronises the strobe into `clk` and edge-detects it.
- Runs a two-pass entry protocol (enter new combo, re-enter to confirm). Commits to `seq` only when both passes match.

---
 rtl/combo_prog.sv | 154 +++++++++++++++
 tb/tb_combo_prog.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/combo_prog.sv
// combo_prog: two-pass combination programming stage feeding the lock FSM.
// Synchronises the keypad strobe, edge-detects it, and commits a new 8-digit
// combination to seq only after the same value is entered twice.
module combo_prog #(
    parameter logic [31:0] DEFAULT_SEQ    = 32'h12345678,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strb,
    input  logic [4:0]  key,
    input  logic        prog_en,
    output logic [31:0] seq,
    output logic [1:0]  mode,
    output logic [31:0] digits,
    output logic [3:0]  cnt,
    output logic        commit,
    output logic        err
);
    localparam int            TW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY1 = 2'd1,
        ENTRY2 = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          s1, s2, s3;
    logic          ev;
    logic [31:0]   sh1, sh1_n, sh2, sh2_n, seq_n;
    logic [3:0]    cnt_n;
    logic [TW-1:0] timer, timer_n;
    logic          commit_n;
    logic          is_hex, is_ent, is_clr, full;
    logic [31:0]   sh_act;

    // one event per strobe rising edge, two flops of synchronisation first
    assign ev     = s2 & ~s3;
    assign is_hex = ~key[4];
    assign is_ent = (key == 5'd16);
    assign is_clr = (key == 5'd17);
    assign full   = (cnt == 4'd8);
    assign sh_act = (state == ENTRY2) ? sh2 : sh1;

    assign mode   = state;
    assign digits = (state == ENTRY2) ? sh2 : sh1;

    // strobe synchroniser and edge-detect history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= strb;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // state and datapath registers; commit/err are registered so no input
    // reaches them combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sh1    <= '0;
            sh2    <= '0;
            seq    <= DEFAULT_SEQ;
            cnt    <= '0;
            timer  <= '0;
            commit <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            sh1    <= sh1_n;
            sh2    <= sh2_n;
            seq    <= seq_n;
            cnt    <= cnt_n;
            timer  <= timer_n;
            commit <= commit_n;
            err    <= (state_n == ERR);
        end
    end

    // next-state logic: prog_en abort beats events, events beat timeout
    always_comb begin
        state_n  = state;
        sh1_n    = sh1;
        sh2_n    = sh2;
        seq_n    = seq;
        cnt_n    = cnt;
        commit_n = 1'b0;
        // timer saturates at the timeout value instead of wrapping
        timer_n  = (timer == TMAX) ? timer : timer + 1'b1;
        case (state)
            IDLE: begin
                if (ev && prog_en && is_ent) begin
                    state_n = ENTRY1;
                    sh1_n   = '0;
                    sh2_n   = '0;
                    cnt_n   = '0;
                    timer_n = '0;
                end
            end
            ENTRY1, ENTRY2: begin
                if (!prog_en) begin
                    state_n = IDLE;
                end else if (ev) begin
                    timer_n = '0;
                    if (is_hex) begin
                        if (!full) begin
                            if (state == ENTRY2) sh2_n = {sh_act[27:0], key[3:0]};
                            else                 sh1_n = {sh_act[27:0], key[3:0]};
                            cnt_n = cnt + 4'd1;
                        end
                    end else if (is_clr) begin
                        if (state == ENTRY2) sh2_n = '0;
                        else                 sh1_n = '0;
                        cnt_n = '0;
                    end else if (is_ent) begin
                        if (!full) begin
                            state_n = ERR;
                        end else if (state == ENTRY1) begin
                            state_n = ENTRY2;
                            cnt_n   = '0;
                            sh2_n   = '0;
                        end else if (sh2 == sh1) begin
                            seq_n    = sh1;
                            commit_n = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            state_n = ERR;
                        end
                    end
                end else if (timer == TMAX) begin
                    state_n = ERR;
                end
            end
            ERR: begin
                // the key that leaves ERR is swallowed
                if (ev) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    sh1_n   = '0;
                    sh2_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_combo_prog.sv
// tb_combo_prog: directed plus randomized key sequences against a
// behavioural model of the two-pass programming protocol.
module tb_combo_prog;
    localparam logic [31:0] DEF = 32'h12345678;
    localparam int          T   = 1000;

    logic        clk = 1'b0, rst = 1'b0, strb = 1'b0, prog_en = 1'b0;
    logic [4:0]  key = 5'd0;
    logic [31:0] seq, digits;
    logic [1:0]  mode;
    logic [3:0]  cnt;
    logic        commit, err;

    combo_prog #(.DEFAULT_SEQ(DEF), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .strb(strb), .key(key), .prog_en(prog_en),
        .seq(seq), .mode(mode), .digits(digits), .cnt(cnt),
        .commit(commit), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // model: mode 0 idle, 1 first pass, 2 confirm pass, 3 error
    int          m_mode, m_cnt;
    logic [31:0] m_sh1, m_sh2, m_seq;
    bit          m_commit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_mode"},   32'(mode),   32'(m_mode));
        chk({tag, "_cnt"},    32'(cnt),    32'(m_cnt));
        chk({tag, "_digits"}, digits,      (m_mode == 2) ? m_sh2 : m_sh1);
        chk({tag, "_seq"},    seq,         m_seq);
        chk({tag, "_err"},    32'(err),    32'(m_mode == 3));
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_sh1 = 0; m_sh2 = 0; m_seq = DEF; m_commit = 0;
    endtask

    // apply one key event to the model following the protocol rules
    task automatic model_ev(input int k);
        m_commit = 0;
        if (m_mode == 0) begin
            if (prog_en && k == 16) begin
                m_mode = 1; m_sh1 = 0; m_sh2 = 0; m_cnt = 0;
            end
        end else if (m_mode == 3) begin
            m_mode = 0; m_cnt = 0; m_sh1 = 0; m_sh2 = 0;
        end else if (!prog_en) begin
            m_mode = 0;
        end else if (k < 16) begin
            if (m_cnt < 8) begin
                if (m_mode == 1) m_sh1 = m_sh1 * 32'd16 + 32'(k);
                else             m_sh2 = m_sh2 * 32'd16 + 32'(k);
                m_cnt++;
            end
        end else if (k == 17) begin
            if (m_mode == 1) m_sh1 = 0; else m_sh2 = 0;
            m_cnt = 0;
        end else if (k == 16) begin
            if (m_cnt < 8)        m_mode = 3;
            else if (m_mode == 1) begin m_mode = 2; m_cnt = 0; m_sh2 = 0; end
            else if (m_sh1 == m_sh2) begin m_seq = m_sh1; m_commit = 1; m_mode = 0; end
            else                  m_mode = 3;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // strobe a key; the update must land on exactly the third edge
    task automatic press(input int k, input int hold);
        int pm;
        pm   = m_mode;
        key  = 5'(k);
        strb = 1'b1;
        step();
        chk("lat1_mode", 32'(mode), 32'(pm));
        chk("lat1_commit", 32'(commit), 32'd0);
        step();
        chk("lat2_mode", 32'(mode), 32'(pm));
        step();
        model_ev(k);
        check_all("press");
        chk("commit", 32'(commit), 32'(m_commit));
        strb = (hold > 0);
        step();
        chk("commit_pulse", 32'(commit), 32'd0);
        repeat (hold) step();
        strb = 1'b0;
        repeat (3) step();
    endtask

    task automatic set_pe(input logic v);
        prog_en = v;
        step();
        if (!v && (m_mode == 1 || m_mode == 2)) m_mode = 0;
        check_all("prog_en");
    endtask

    task automatic enter_pass(input logic [31:0] c);
        for (int i = 0; i < 8; i++) press(int'(c[31-4*i -: 4]), 0);
        press(16, 0);
    endtask

    task automatic go_idle();
        if (m_mode == 3) press(0, 0);
        if (m_mode == 1 || m_mode == 2) begin
            set_pe(1'b0);
            set_pe(1'b1);
        end
    endtask

    initial begin
        logic [31:0] c;
        model_reset();
        #2 rst = 1'b1;
        #10;
        check_all("in_reset");
        chk("in_reset_commit", 32'(commit), 32'd0);
        #3 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_seq", seq, DEF);
            chk("hold_mode", 32'(mode), 32'd0);
            chk("hold_commit", 32'(commit), 32'd0);
        end
        // programming not permitted: keys do nothing
        press(16, 0); press(3, 0); press(16, 0);

        // directed commit of 87654321
        prog_en = 1'b1;
        press(16, 0);
        enter_pass(32'h87654321);
        enter_pass(32'h87654321);
        chk("commit_seq", seq, 32'h87654321);

        // saturation at 8 digits, CLEAR, short ENTER error, exit from ERR
        press(16, 0);
        for (int d = 1; d <= 9; d++) press(d, 0);
        chk("sat_cnt", 32'(cnt), 32'd8);
        chk("sat_digits", digits, 32'h12345678);
        press(17, 0);
        press(16, 0);
        chk("short_err", 32'(mode), 32'd3);
        press(18, 0);
        chk("err_exit", 32'(mode), 32'd0);

        // mismatched confirm pass
        press(16, 0);
        enter_pass(32'h11111111);
        enter_pass(32'h11111112);
        chk("mismatch_mode", 32'(mode), 32'd3);
        chk("mismatch_seq", seq, 32'h87654321);
        press(5, 0);

        // timeout: last digit lands at edge L, press() returns at L+4
        press(16, 0); press(1, 0); press(2, 0); press(3, 0);
        repeat (T - 5) step();
        check_all("pre_timeout");
        step();
        m_mode = 3;
        check_all("timeout");
        press(4, 0);

        // event landing on the timeout edge wins
        press(16, 0); press(1, 0); press(2, 0); press(3, 0);
        repeat (T - 7) step();
        press(4, 0);
        chk("boundary_mode", 32'(mode), 32'd1);
        chk("boundary_cnt", 32'(cnt), 32'd4);

        // held strobe yields a single digit
        press(7, 50);
        check_all("hold_strb");
        chk("hold_cnt", 32'(cnt), 32'd5);

        // prog_en drop during confirm pass
        set_pe(1'b0); set_pe(1'b1);
        press(16, 0);
        enter_pass(32'hABCDEF01);
        press(2, 0); press(9, 0);
        set_pe(1'b0);
        chk("abort_mode", 32'(mode), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        set_pe(1'b1);

        // random combos committed end to end
        for (int r = 0; r < 3; r++) begin
            c = $urandom;
            go_idle();
            press(16, 0);
            enter_pass(c);
            enter_pass(c);
            chk("rand_commit_seq", seq, c);
        end

        // random key storm
        for (int r = 0; r < 40; r++) press(int'($urandom_range(0, 19)), 0);

        // async reset mid confirm pass after a commit
        go_idle();
        press(16, 0);
        enter_pass(32'h0F0F1234);
        press(6, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_commit", 32'(commit), 32'd0);
        #3 rst = 1'b0;
        step();
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
